// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: response owner encoding and starvation counter width.
// Pure declarations; no latency or backpressure of its own.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D_RD = 2'd2,
      OWN_D_WR = 2'd3
   } owner_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory macro port of the arbiter.
// slave = arbiter side; master = pipeline stages plus memory macro side.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_stall;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_stall;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive conflicts lost by fetch; clear has priority over increment.
// One-cycle update latency; at_max is combinational from the current count.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                clr,
   output logic [STARVE_W-1:0] cnt,
   output logic                at_max
);

   localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

   assign at_max = (cnt == MAX_V);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_max) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store: one issue per cycle, response next cycle.
// Loser gets a same-cycle combinational stall; data wins conflicts until fetch has lost STARVE_MAX in a row.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   unified_mem_arbiter_if.slave  bus
);

   logic                if_grant;
   logic                d_grant;
   logic                starve_at_max;
   logic [STARVE_W-1:0] starve_cnt;
   owner_t              owner;
   owner_t              owner_nxt;

   // Reset also blocks grants so nothing is issued while rst is high.
   assign if_grant = !rst && bus.if_req && (!bus.d_req || starve_at_max);
   assign d_grant  = !rst && bus.d_req && !if_grant;

   assign bus.if_stall = bus.if_req && !if_grant;
   assign bus.d_stall  = bus.d_req && !d_grant;

   arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc    (bus.if_req && d_grant),
      .clr    (if_grant || !bus.if_req),
      .cnt    (starve_cnt),
      .at_max (starve_at_max)
   );

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      owner_nxt     = OWN_NONE;
      if (if_grant) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.if_addr[ADDR_W-1:2];
         owner_nxt    = OWN_IF;
      end else if (d_grant) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.d_we;
         bus.mem_addr = bus.d_addr[ADDR_W-1:2];
         if (bus.d_we) begin
            bus.mem_wdata = bus.d_wdata;
            owner_nxt     = OWN_D_WR;
         end else begin
            owner_nxt     = OWN_D_RD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_nxt;
      end
   end

   // Store acknowledges carry no data, so d_rdata stays zero for OWN_D_WR.
   assign bus.if_valid = (owner == OWN_IF);
   assign bus.if_rdata = (owner == OWN_IF) ? bus.mem_rdata : '0;
   assign bus.d_valid  = (owner == OWN_D_RD) || (owner == OWN_D_WR);
   assign bus.d_rdata  = (owner == OWN_D_RD) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized checks of unified_mem_arbiter against a transaction-level model with its own memory image.
module tb_unified_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int SMAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b ();

   unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   // Memory macro stand-in: synchronous read, one-cycle latency.
   logic [31:0] mem_arr [0:63];
   always @(posedge clk) begin
      if (b.mem_en) begin
         if (b.mem_we) mem_arr[b.mem_addr] <= b.mem_wdata;
         else          b.mem_rdata <= mem_arr[b.mem_addr];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:63];
   int          starve;
   int          pend_kind;   // 0 none, 1 fetch read, 2 data read, 3 data write
   logic [31:0] pend_data;
   logic        last_if_stall, last_d_stall;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ir, input logic [7:0] ia, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [31:0] wd);
      int g;   // 0 none, 1 fetch, 2 data
      b.if_req  = ir;
      b.if_addr = ia;
      b.d_req   = dr;
      b.d_we    = dw;
      b.d_addr  = da;
      b.d_wdata = wd;
      #1;
      if (ir && dr)  g = (starve == SMAX) ? 1 : 2;
      else if (ir)   g = 1;
      else if (dr)   g = 2;
      else           g = 0;

      chk("if_stall",  32'(b.if_stall),  32'(ir && g != 1));
      chk("d_stall",   32'(b.d_stall),   32'(dr && g != 2));
      chk("mem_en",    32'(b.mem_en),    32'(g != 0));
      chk("mem_we",    32'(b.mem_we),    32'(g == 2 && dw));
      chk("mem_addr",  32'(b.mem_addr),  (g == 1) ? 32'(ia >> 2) : (g == 2) ? 32'(da >> 2) : 32'd0);
      chk("mem_wdata", b.mem_wdata,      (g == 2 && dw) ? wd : 32'd0);
      chk("if_valid",  32'(b.if_valid),  32'(pend_kind == 1));
      chk("if_rdata",  b.if_rdata,       (pend_kind == 1) ? pend_data : 32'd0);
      chk("d_valid",   32'(b.d_valid),   32'(pend_kind == 2 || pend_kind == 3));
      chk("d_rdata",   b.d_rdata,        (pend_kind == 2) ? pend_data : 32'd0);
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(starve));

      if (g == 2 && ir) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      else              starve = 0;
      pend_data = 32'd0;
      if (g == 0) begin
         pend_kind = 0;
      end else if (g == 1) begin
         pend_kind = 1;
         pend_data = ref_mem[ia >> 2];
      end else if (dw) begin
         pend_kind = 3;
         ref_mem[da >> 2] = wd;
      end else begin
         pend_kind = 2;
         pend_data = ref_mem[da >> 2];
      end
      last_if_stall = ir && g != 1;
      last_d_stall  = dr && g != 2;
      @(negedge clk);
   endtask

   initial begin
      logic        ir, dr, dw;
      logic [7:0]  ia, da;
      logic [31:0] wd;
      int          exp_seq [5];
      exp_seq = '{1, 2, 3, 0, 1};

      for (int i = 0; i < 64; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      b.mem_rdata = 32'd0;
      starve = 0; pend_kind = 0; pend_data = 0;
      last_if_stall = 0; last_d_stall = 0;

      // Reset state, with requests present that must not be granted
      b.if_req = 1; b.if_addr = 8'h04; b.d_req = 1; b.d_we = 1;
      b.d_addr = 8'h08; b.d_wdata = 32'hdead;
      #2;
      chk("rst_owner",    32'(dut.owner), 32'(OWN_NONE));
      chk("rst_starve",   32'(dut.starve_cnt), 32'd0);
      chk("rst_if_valid", 32'(b.if_valid), 32'd0);
      chk("rst_d_valid",  32'(b.d_valid), 32'd0);
      chk("rst_if_rdata", b.if_rdata, 32'd0);
      chk("rst_d_rdata",  b.d_rdata, 32'd0);
      chk("rst_mem_en",   32'(b.mem_en), 32'd0);
      chk("rst_mem_we",   32'(b.mem_we), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      // Fetch only, consecutive words
      step(1, 8'h04, 0, 0, 8'h00, 0);
      step(1, 8'h08, 0, 0, 8'h00, 0);
      step(1, 8'h0C, 0, 0, 8'h00, 0);
      step(0, 8'h00, 0, 0, 8'h00, 0);

      // Conflict: data wins, then fetch issues once data drops
      step(1, 8'h10, 1, 0, 8'h0C, 0);
      step(1, 8'h10, 0, 0, 8'h00, 0);
      step(0, 8'h00, 0, 0, 8'h00, 0);

      // Sustained conflict: grants D,D,D,IF,D
      for (int i = 0; i < 5; i++) begin
         step(1, 8'h20, 1, 0, 8'h30, 0);
         chk("starve_seq", 32'(dut.starve_cnt), 32'(exp_seq[i]));
      end
      step(0, 8'h00, 0, 0, 8'h00, 0);

      // Store with unaligned low bits, then read back
      step(0, 8'h00, 1, 1, 8'h0F, 32'h11);
      step(0, 8'h00, 1, 0, 8'h0C, 0);
      step(0, 8'h00, 0, 0, 8'h00, 0);

      // Reset pulsed between a fetch issue and its response
      step(1, 8'h14, 0, 0, 8'h00, 0);
      rst = 1;
      #1;
      chk("mid_rst_if_valid", 32'(b.if_valid), 32'd0);
      chk("mid_rst_owner",    32'(dut.owner), 32'(OWN_NONE));
      chk("mid_rst_starve",   32'(dut.starve_cnt), 32'd0);
      chk("mid_rst_mem_en",   32'(b.mem_en), 32'd0);
      #1;
      rst = 0;
      pend_kind = 0;
      starve = 0;
      #1;
      step(0, 8'h00, 0, 0, 8'h00, 0);

      // Idle
      for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 8'h00, 0);

      // Randomized traffic; stalled requesters hold their request stable
      ir = 0; dr = 0; dw = 0; ia = 0; da = 0; wd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!last_if_stall) begin
            ir = ($urandom_range(0, 3) != 0);
            ia = 8'($urandom);
         end
         if (!last_d_stall) begin
            dr = ($urandom_range(0, 2) != 0);
            dw = $urandom_range(0, 1) == 1;
            da = 8'($urandom);
            wd = $urandom;
         end
         step(ir, ia, dr, dw, da, wd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, word-organised unified memory between the pipeline's instruction-fetch port and its load/store port, replacing separate instruction and data memories. One access is issued per cycle. Requests that lose arbitration receive a combinational stall. A starvation counter ensures fetch progress under sustained data traffic. The block sits between the IF/MEM stages and the memory macro; the memory has one-cycle synchronous read latency.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of both requester ports
- DATA_W, 32, data width
- STARVE_MAX, 3, consecutive lost conflicts after which fetch wins; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address
- if_stall  out  1  fetch request present but not granted this cycle
- if_valid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_stall  out  1  data request present but not granted
- d_valid  out  1  load data valid or store acknowledge
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address (byte address >> 2)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read issue

## Operation
- Grant is combinational per cycle:
  - Only one requester asserted: it is granted.
  - Both asserted: data wins, unless starve_cnt == STARVE_MAX; then fetch wins.
- starve_cnt is 4 bits.
  - Increments when both request and data is granted.
  - Clears when fetch is granted or when if_req is low.
  - Never exceeds STARVE_MAX.
- Granted access drives:
  - mem_en=1
  - mem_addr = addr[ADDR_W-1:2]; addr[1:0] ignored
  - mem_we = d_we for data, 0 for fetch
  - mem_wdata = d_wdata for data, 0 otherwise
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- x_stall = x_req & ~x_grant.
- owner register, captured each cycle, takes one of:
  - OWN_NONE
  - OWN_IF
  - OWN_D_RD
  - OWN_D_WR
- Response phase, the cycle after issue:
  - OWN_IF: if_valid=1, if_rdata=mem_rdata.
  - OWN_D_RD: d_valid=1, d_rdata=mem_rdata.
  - OWN_D_WR: d_valid=1, d_rdata=0.
  - Any rdata is 0 while its valid is low.
- Requesters hold request, address and data stable while stalled.

## Timing
- Issue cycle N, response cycle N+1; a new issue may occur in N+1, so throughput is one access per cycle.
- Stall is same-cycle combinational from req and starve_cnt.
- Reset values:
  - owner=OWN_NONE, starve_cnt=0
  - if_valid=d_valid=0; if_rdata=d_rdata=0
  - mem outputs follow grant rules; with no requests, all 0
- Reset asserted mid-operation: the pending response is dropped. No valid in the cycle after reset release unless a new issue occurred.
- Requests during reset are not granted.
- A request arriving and dropping in the same cycle without grant is lost; no queuing.
- starve_cnt saturation: at STARVE_MAX with both requesting, fetch wins and the counter clears the same edge.

## Structure
- Shared package `mem_arb_pkg`:
  - owner enum (OWN_NONE, OWN_IF, OWN_D_RD, OWN_D_WR)
  - STARVE_W=4 constant
- Sub-module `arb_starve_ctr`: saturating counter with inc/clr inputs and an at_max output.
- Top level holds grant logic, the owner register and response muxing.

## Test plan
- Fetch only: if_req=1, if_addr=0x04,0x08,0x0C on consecutive cycles.
  - Required: mem_addr=1,2,3 with mem_en=1.
  - Required: if_valid=1 one cycle later each, with if_rdata=mem_rdata; d_valid=0 throughout.
- Conflict: both request, d_we=0, d_addr=0x0C, if_addr=0x10.
  - Cycle 0: mem_addr=3, if_stall=1, d_stall=0.
  - Cycle 1: d_valid=1; d_req dropped, fetch issues mem_addr=4.
  - Cycle 2: if_valid=1.
- Starvation with STARVE_MAX=3: both held high for 5 cycles.
  - Required grant sequence: D,D,D,IF,D.
  - Required starve_cnt: 1,2,3,0,1.
- Store: d_we=1, d_addr=0x0C, d_wdata=0x11.
  - Required: mem_en=1, mem_we=1, mem_addr=3, mem_wdata=0x11.
  - Next cycle: d_valid=1, d_rdata=0.
- Reset mid-read: fetch issue at cycle N, rst pulsed asynchronously in cycle N+1 before the edge.
  - Required: if_valid=0, owner=OWN_NONE, starve_cnt=0 after release.
- Idle: no requests for 4 cycles.
  - Required: all mem outputs 0, both valids 0, both stalls 0.
